// File: rtl/prefetch_pkg.sv
// Shared widths, IDs and types for the prefetch issue arbiter.
// Imported by the interface, the FIFO-side top and the testbench.
package prefetch_pkg;

    localparam int ADDR_BITS         = 64;
    localparam int ID_BITS           = 4;
    localparam logic [ID_BITS-1:0] PF_ID = 4'hF;
    localparam int LOG_OUTSTAND_REQS = 6;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } ar_state_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [ID_BITS-1:0]   id;
        logic                 is_prefetch;
    } ar_req_t;

endpackage

// File: rtl/prefetch_issue_arbiter_if.sv
// Bundle of demand, prefetch, AR and retire signals around the arbiter.
// master = environment side, slave = arbiter side.
interface prefetch_issue_arbiter_if #(
    parameter int PF_QUEUE_DEPTH = 4
);
    import prefetch_pkg::*;

    localparam int QCNT_BITS = $clog2(PF_QUEUE_DEPTH) + 1;

    logic                         en;
    logic                         demandValid;
    logic [ADDR_BITS-1:0]         demandAddr;
    logic [ID_BITS-1:0]           demandId;
    logic                         demandReady;
    logic                         pfValid;
    logic [ADDR_BITS-1:0]         pfAddr;
    logic                         pfReady;
    logic                         flush;
    logic [LOG_OUTSTAND_REQS-1:0] outstandingReqLimit;
    logic                         arValid;
    logic [ADDR_BITS-1:0]         arAddr;
    logic [ID_BITS-1:0]           arId;
    logic                         arIsPrefetch;
    logic                         arReady;
    logic                         rDoneValid;
    logic                         rDoneIsPrefetch;
    logic [LOG_OUTSTAND_REQS-1:0] outstandingReqCnt;
    logic [QCNT_BITS-1:0]         pfQueueCnt;

    modport master (
        output en, demandValid, demandAddr, demandId, pfValid, pfAddr, flush,
               outstandingReqLimit, arReady, rDoneValid, rDoneIsPrefetch,
        input  demandReady, pfReady, arValid, arAddr, arId, arIsPrefetch,
               outstandingReqCnt, pfQueueCnt
    );

    modport slave (
        input  en, demandValid, demandAddr, demandId, pfValid, pfAddr, flush,
               outstandingReqLimit, arReady, rDoneValid, rDoneIsPrefetch,
        output demandReady, pfReady, arValid, arAddr, arId, arIsPrefetch,
               outstandingReqCnt, pfQueueCnt
    );

endinterface

// File: rtl/pf_addr_fifo.sv
// Small synchronous FIFO for prefetch addresses with flush and occupancy count.
// Push is ignored when full, pop when empty; flush beats both.
module pf_addr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = 1;
    localparam logic [PTR_BITS:0]   CNT_ONE  = 1;
    localparam logic [PTR_BITS:0]   FULL_CNT = DEPTH[PTR_BITS:0];

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/prefetch_issue_arbiter.sv
// Arbitrates one AR channel between demand reads and queued prefetches, with
// in-flight throttling, a starvation guard and outstanding-prefetch accounting.
module prefetch_issue_arbiter
    import prefetch_pkg::*;
#(
    parameter int PF_QUEUE_DEPTH = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    prefetch_issue_arbiter_if.slave   bus
);

    localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_BITS-1:0]       STARVE_MAX = STARVE_LIMIT[STARVE_BITS-1:0];
    localparam logic [STARVE_BITS-1:0]       STARVE_ONE = 1;
    localparam logic [LOG_OUTSTAND_REQS-1:0] CNT_ONE    = 1;

    ar_state_e                    state_q, state_d;
    ar_req_t                      ar_q, ar_d;
    logic [STARVE_BITS-1:0]       starve_q;
    logic [LOG_OUTSTAND_REQS-1:0] out_cnt_q;

    logic                         fifo_full, fifo_empty;
    logic [ADDR_BITS-1:0]         fifo_rdata;
    logic [$clog2(PF_QUEUE_DEPTH):0] fifo_count;

    logic                         ar_hs, slot_free, held_pf, pf_eligible, starve_hit;
    logic                         grant_pf, grant_dem, issue_pf, retire_pf;
    logic [LOG_OUTSTAND_REQS:0]   inflight;

    pf_addr_fifo #(
        .DEPTH (PF_QUEUE_DEPTH),
        .WIDTH (ADDR_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.pfValid && !fifo_full),
        .pop   (grant_pf),
        .flush (bus.flush),
        .wdata (bus.pfAddr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ar_hs      = (state_q == S_HOLD) && bus.arReady;
    assign slot_free  = (state_q == S_EMPTY) || bus.arReady;
    assign held_pf    = (state_q == S_HOLD) && ar_q.is_prefetch;
    // A prefetch sitting on AR counts against the limit before its handshake.
    assign inflight   = {1'b0, out_cnt_q} + {{LOG_OUTSTAND_REQS{1'b0}}, held_pf};
    assign pf_eligible = !fifo_empty && (inflight < {1'b0, bus.outstandingReqLimit});
    assign starve_hit = (starve_q == STARVE_MAX);
    assign issue_pf   = ar_hs && ar_q.is_prefetch;
    assign retire_pf  = bus.rDoneValid && bus.rDoneIsPrefetch;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ar_d      = ar_q;
        grant_pf  = 1'b0;
        grant_dem = 1'b0;
        if (bus.en && slot_free) begin
            if (pf_eligible && (starve_hit || !bus.demandValid)) grant_pf  = 1'b1;
            else if (bus.demandValid)                            grant_dem = 1'b1;
        end
        if (grant_pf) begin
            ar_d    = '{addr: fifo_rdata, id: PF_ID, is_prefetch: 1'b1};
            state_d = S_HOLD;
        end else if (grant_dem) begin
            ar_d    = '{addr: bus.demandAddr, id: bus.demandId, is_prefetch: 1'b0};
            state_d = S_HOLD;
        end else if (ar_hs) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            ar_q    <= '0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (bus.flush || fifo_empty || grant_pf) begin
            starve_q <= '0;
        end else if (grant_dem && pf_eligible && !starve_hit) begin
            starve_q <= starve_q + STARVE_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_cnt_q <= '0;
        end else if (issue_pf && !retire_pf) begin
            out_cnt_q <= out_cnt_q + CNT_ONE;
        end else if (retire_pf && !issue_pf && out_cnt_q != '0) begin
            out_cnt_q <= out_cnt_q - CNT_ONE;
        end
    end

    underflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(retire_pf && !issue_pf && out_cnt_q == '0))
        else $warning("prefetch retire with zero outstanding count");

    assign bus.demandReady       = grant_dem;
    assign bus.pfReady           = !fifo_full;
    assign bus.pfQueueCnt        = fifo_count;
    assign bus.arValid           = (state_q == S_HOLD);
    assign bus.arAddr            = ar_q.addr;
    assign bus.arId              = ar_q.id;
    assign bus.arIsPrefetch      = ar_q.is_prefetch;
    assign bus.outstandingReqCnt = out_cnt_q;

endmodule

// File: tb/tb_prefetch_issue_arbiter.sv
// Scenario tasks plus a randomized run against a queue-based reference model.
module tb_prefetch_issue_arbiter;
    import prefetch_pkg::*;

    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prefetch_issue_arbiter_if #(.PF_QUEUE_DEPTH(DEPTH)) bus ();

    prefetch_issue_arbiter #(
        .PF_QUEUE_DEPTH (DEPTH),
        .STARVE_LIMIT   (STARVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of prefetch addresses, one pending AR, counters.
    logic [ADDR_BITS-1:0] mq[$];
    bit      m_hold;
    ar_req_t m_ar;
    int      m_cnt;
    int      m_starve;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b1; bus.demandValid = 1'b0; bus.demandAddr = '0; bus.demandId = '0;
        bus.pfValid = 1'b0; bus.pfAddr = '0; bus.flush = 1'b0; bus.outstandingReqLimit = 6'd8;
        bus.arReady = 1'b0; bus.rDoneValid = 1'b0; bus.rDoneIsPrefetch = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        repeat (2) clk_step();
        reset = 1'b0;
        clk_step();
        mq.delete(); m_hold = 0; m_ar = '0; m_cnt = 0; m_starve = 0;
    endtask

    function automatic bit m_pf_ok();
        int held;
        held = (m_hold && m_ar.is_prefetch) ? 1 : 0;
        return mq.size() > 0 && (m_cnt + held) < int'(bus.outstandingReqLimit);
    endfunction

    // 0 = no grant, 1 = demand, 2 = prefetch
    function automatic int m_decide();
        bit ok;
        ok = m_pf_ok();
        if (!(bus.en && (!m_hold || bus.arReady))) return 0;
        if (m_starve == STARVE && ok) return 2;
        if (bus.demandValid) return 1;
        if (ok) return 2;
        return 0;
    endfunction

    task automatic model_tick(input int g);
        bit ok, hs, push_ok, ret, inc;
        ok      = m_pf_ok();
        hs      = m_hold && bus.arReady;
        push_ok = bus.pfValid && mq.size() < DEPTH && !bus.flush;
        ret     = bus.rDoneValid && bus.rDoneIsPrefetch;
        inc     = hs && m_ar.is_prefetch;
        if (inc && !ret) m_cnt++;
        else if (ret && !inc && m_cnt > 0) m_cnt--;
        if (bus.flush || mq.size() == 0 || g == 2) m_starve = 0;
        else if (g == 1 && ok && m_starve < STARVE) m_starve++;
        if (g == 2) begin
            m_ar = '{addr: mq.pop_front(), id: PF_ID, is_prefetch: 1'b1};
            m_hold = 1;
        end else if (g == 1) begin
            m_ar = '{addr: bus.demandAddr, id: bus.demandId, is_prefetch: 1'b0};
            m_hold = 1;
        end else if (hs) begin
            m_hold = 0;
        end
        if (bus.flush) mq.delete();
        else if (push_ok) mq.push_back(bus.pfAddr);
    endtask

    task automatic test_reset();
        apply_reset();
        bus.pfValid = 1'b1; bus.pfAddr = 64'h55;
        clk_step();
        bus.pfValid = 1'b0;
        clk_step();
        n_cmp++; if (bus.arValid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_arValid: got %0h want 1", bus.arValid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.arValid !== 1'b0) begin n_bad++; $display("FAIL reset_arValid: got %0h want 0", bus.arValid); end
        n_cmp++; if (bus.arAddr !== '0) begin n_bad++; $display("FAIL reset_arAddr: got %0h want 0", bus.arAddr); end
        n_cmp++; if (bus.arId !== '0) begin n_bad++; $display("FAIL reset_arId: got %0h want 0", bus.arId); end
        n_cmp++; if (bus.arIsPrefetch !== 1'b0) begin n_bad++; $display("FAIL reset_arIsPrefetch: got %0h want 0", bus.arIsPrefetch); end
        n_cmp++; if (bus.outstandingReqCnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.outstandingReqCnt); end
        n_cmp++; if (bus.pfReady !== 1'b1) begin n_bad++; $display("FAIL reset_pfReady: got %0h want 1", bus.pfReady); end
        n_cmp++; if (bus.pfQueueCnt !== '0) begin n_bad++; $display("FAIL reset_qcnt: got %0d want 0", bus.pfQueueCnt); end
        clk_step();
        reset = 1'b0;
    endtask

    task automatic test_pf_stream();
        int bc[$];
        logic [ADDR_BITS-1:0] ba[$];
        logic [ID_BITS-1:0] bi[$];
        int cnts[12];
        apply_reset();
        bus.arReady = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.pfValid = (c < 3);
            bus.pfAddr  = 64'h1000 + 64'(c) * 64'h40;
            #1;
            if (bus.arValid && bus.arReady) begin
                bc.push_back(c); ba.push_back(bus.arAddr); bi.push_back(bus.arId);
            end
            cnts[c] = int'(bus.outstandingReqCnt);
            clk_step();
        end
        n_cmp++; if (bc.size() != 3) begin n_bad++; $display("FAIL stream_beats: got %0d want 3", bc.size()); end
        for (int k = 0; k < 3 && k < bc.size(); k++) begin
            n_cmp++; if (ba[k] !== 64'h1000 + 64'(k) * 64'h40) begin n_bad++; $display("FAIL stream_addr%0d: got %0h want %0h", k, ba[k], 64'h1000 + 64'(k) * 64'h40); end
            n_cmp++; if (bi[k] !== PF_ID) begin n_bad++; $display("FAIL stream_id%0d: got %0h want %0h", k, bi[k], PF_ID); end
            n_cmp++; if (bc[k] != bc[0] + k) begin n_bad++; $display("FAIL stream_cycle%0d: got %0d want %0d", k, bc[k], bc[0] + k); end
            n_cmp++; if (cnts[bc[k] + 1] != k + 1) begin n_bad++; $display("FAIL stream_cnt%0d: got %0d want %0d", k, cnts[bc[k] + 1], k + 1); end
        end
    endtask

    task automatic test_limit();
        int beats;
        int hit;
        logic [ADDR_BITS-1:0] hit_addr;
        apply_reset();
        bus.outstandingReqLimit = 6'd2;
        bus.arReady = 1'b1;
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            bus.pfValid = (c < 3);
            bus.pfAddr  = 64'h1000 + 64'(c) * 64'h40;
            #1;
            if (bus.arValid) beats++;
            clk_step();
        end
        n_cmp++; if (beats != 2) begin n_bad++; $display("FAIL limit_beats: got %0d want 2", beats); end
        n_cmp++; if (bus.outstandingReqCnt !== 6'd2) begin n_bad++; $display("FAIL limit_cnt: got %0d want 2", bus.outstandingReqCnt); end
        n_cmp++; if (bus.pfQueueCnt !== 3'd1) begin n_bad++; $display("FAIL limit_qcnt: got %0d want 1", bus.pfQueueCnt); end
        bus.rDoneValid = 1'b1; bus.rDoneIsPrefetch = 1'b1;
        clk_step();
        bus.rDoneValid = 1'b0; bus.rDoneIsPrefetch = 1'b0;
        hit = -1; hit_addr = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.arValid && hit < 0) begin hit = i; hit_addr = bus.arAddr; end
            clk_step();
        end
        n_cmp++; if (hit != 1) begin n_bad++; $display("FAIL limit_reissue_cycle: got %0d want 1", hit); end
        n_cmp++; if (hit_addr !== 64'h1080) begin n_bad++; $display("FAIL limit_reissue_addr: got %0h want 1080", hit_addr); end
        n_cmp++; if (bus.outstandingReqCnt !== 6'd2) begin n_bad++; $display("FAIL limit_cnt_after: got %0d want 2", bus.outstandingReqCnt); end
    endtask

    task automatic test_starvation();
        bit kinds[$];
        logic [ADDR_BITS-1:0] pf_addr_seen;
        logic [ID_BITS-1:0] pf_id_seen;
        apply_reset();
        bus.en = 1'b0; bus.pfValid = 1'b1; bus.pfAddr = 64'h2000;
        clk_step();
        bus.pfValid = 1'b0; bus.en = 1'b1; bus.demandValid = 1'b1; bus.demandId = 4'h2; bus.arReady = 1'b1;
        pf_addr_seen = '0; pf_id_seen = '0;
        for (int c = 0; c < 16; c++) begin
            bus.demandAddr = 64'h100 * 64'(c + 1);
            #1;
            if (bus.arValid) begin
                kinds.push_back(bus.arIsPrefetch);
                if (bus.arIsPrefetch) begin pf_addr_seen = bus.arAddr; pf_id_seen = bus.arId; end
            end
            clk_step();
        end
        n_cmp++; if (kinds.size() < 12) begin n_bad++; $display("FAIL starve_beats: got %0d want >=12", kinds.size()); end
        for (int k = 0; k < 12 && k < kinds.size(); k++) begin
            n_cmp++; if (kinds[k] != (k == STARVE)) begin n_bad++; $display("FAIL starve_kind%0d: got %0d want %0d", k, kinds[k], (k == STARVE)); end
        end
        n_cmp++; if (pf_addr_seen !== 64'h2000) begin n_bad++; $display("FAIL starve_pf_addr: got %0h want 2000", pf_addr_seen); end
        n_cmp++; if (pf_id_seen !== PF_ID) begin n_bad++; $display("FAIL starve_pf_id: got %0h want %0h", pf_id_seen, PF_ID); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.demandValid = 1'b1; bus.demandAddr = 64'hA000; bus.demandId = 4'h3;
        #1;
        n_cmp++; if (bus.demandReady !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready: got %0h want 1", bus.demandReady); end
        clk_step();
        bus.demandAddr = 64'hB000; bus.demandId = 4'h5;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (bus.arValid !== 1'b1 || bus.arAddr !== 64'hA000 || bus.arId !== 4'h3) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%0h a=%0h id=%0h want v=1 a=a000 id=3", i, bus.arValid, bus.arAddr, bus.arId); end
            n_cmp++; if (bus.demandReady !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready%0d: got %0h want 0", i, bus.demandReady); end
            clk_step();
        end
        bus.arReady = 1'b1;
        #1;
        n_cmp++; if (bus.demandReady !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %0h want 1", bus.demandReady); end
        clk_step();
        bus.demandValid = 1'b0; bus.arReady = 1'b0;
        #1;
        n_cmp++; if (bus.arValid !== 1'b1 || bus.arAddr !== 64'hB000 || bus.arId !== 4'h5 || bus.arIsPrefetch !== 1'b0) begin
            n_bad++; $display("FAIL bp_second: got v=%0h a=%0h id=%0h pf=%0h want v=1 a=b000 id=5 pf=0", bus.arValid, bus.arAddr, bus.arId, bus.arIsPrefetch); end
    endtask

    task automatic test_flush();
        int extra;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            bus.pfValid = 1'b1; bus.pfAddr = 64'h3000 + 64'(i) * 64'h40;
            clk_step();
        end
        bus.pfAddr = 64'h9999;
        #1;
        n_cmp++; if (bus.pfReady !== 1'b0) begin n_bad++; $display("FAIL flush_full_ready: got %0h want 0", bus.pfReady); end
        n_cmp++; if (bus.pfQueueCnt !== 3'd4) begin n_bad++; $display("FAIL flush_full_qcnt: got %0d want 4", bus.pfQueueCnt); end
        clk_step();
        n_cmp++; if (bus.pfQueueCnt !== 3'd4) begin n_bad++; $display("FAIL flush_reject_qcnt: got %0d want 4", bus.pfQueueCnt); end
        bus.pfValid = 1'b0; bus.flush = 1'b1;
        clk_step();
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.pfQueueCnt !== '0 || bus.pfReady !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got q=%0d r=%0h want q=0 r=1", bus.pfQueueCnt, bus.pfReady); end
        n_cmp++; if (bus.arValid !== 1'b1 || bus.arAddr !== 64'h3000 || bus.arIsPrefetch !== 1'b1) begin
            n_bad++; $display("FAIL flush_held: got v=%0h a=%0h pf=%0h want v=1 a=3000 pf=1", bus.arValid, bus.arAddr, bus.arIsPrefetch); end
        bus.arReady = 1'b1;
        clk_step();
        n_cmp++; if (bus.outstandingReqCnt !== 6'd1) begin n_bad++; $display("FAIL flush_cnt: got %0d want 1", bus.outstandingReqCnt); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.arValid) extra++;
            clk_step();
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL flush_no_more: got %0d want 0", extra); end
    endtask

    task automatic test_count_edges();
        apply_reset();
        bus.pfValid = 1'b1; bus.pfAddr = 64'h4000;
        clk_step();
        bus.pfAddr = 64'h4040;
        clk_step();
        bus.pfValid = 1'b0;
        #1;
        n_cmp++; if (bus.arValid !== 1'b1 || bus.arAddr !== 64'h4000) begin n_bad++; $display("FAIL edge_held: got v=%0h a=%0h want v=1 a=4000", bus.arValid, bus.arAddr); end
        bus.arReady = 1'b1;
        clk_step();
        bus.arReady = 1'b0;
        #1;
        n_cmp++; if (bus.outstandingReqCnt !== 6'd1 || bus.arAddr !== 64'h4040) begin n_bad++; $display("FAIL edge_first: got c=%0d a=%0h want c=1 a=4040", bus.outstandingReqCnt, bus.arAddr); end
        bus.arReady = 1'b1; bus.rDoneValid = 1'b1; bus.rDoneIsPrefetch = 1'b1;
        clk_step();
        bus.arReady = 1'b0; bus.rDoneValid = 1'b0; bus.rDoneIsPrefetch = 1'b0;
        #1;
        n_cmp++; if (bus.outstandingReqCnt !== 6'd1) begin n_bad++; $display("FAIL edge_same_cycle: got %0d want 1", bus.outstandingReqCnt); end
        bus.rDoneValid = 1'b1; bus.rDoneIsPrefetch = 1'b1;
        clk_step();
        #1;
        n_cmp++; if (bus.outstandingReqCnt !== '0) begin n_bad++; $display("FAIL edge_retire: got %0d want 0", bus.outstandingReqCnt); end
        clk_step();
        bus.rDoneValid = 1'b0; bus.rDoneIsPrefetch = 1'b0;
        #1;
        n_cmp++; if (bus.outstandingReqCnt !== '0) begin n_bad++; $display("FAIL edge_underflow_hold: got %0d want 0", bus.outstandingReqCnt); end
    endtask

    task automatic test_random();
        int g;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) bus.outstandingReqLimit = 6'($urandom_range(0, 6));
            bus.en          = ($urandom_range(0, 9) != 0);
            bus.demandValid = ($urandom_range(0, 2) == 0);
            bus.demandAddr  = {$urandom, $urandom};
            bus.demandId    = 4'($urandom_range(0, 14));
            bus.pfValid     = $urandom_range(0, 1) == 1;
            bus.pfAddr      = {$urandom, $urandom};
            bus.arReady     = ($urandom_range(0, 3) != 0);
            bus.rDoneValid  = ($urandom_range(0, 2) == 0);
            bus.rDoneIsPrefetch = bus.rDoneValid && m_cnt > 0 && ($urandom_range(0, 1) == 1);
            #1;
            g = m_decide();
            n_cmp++; if (bus.demandReady !== (g == 1)) begin n_bad++; $display("FAIL rnd_demandReady c%0d: got %0h want %0h", c, bus.demandReady, (g == 1)); end
            n_cmp++; if (bus.arValid !== m_hold) begin n_bad++; $display("FAIL rnd_arValid c%0d: got %0h want %0h", c, bus.arValid, m_hold); end
            if (m_hold) begin
                n_cmp++; if ({bus.arAddr, bus.arId, bus.arIsPrefetch} !== m_ar) begin
                    n_bad++; $display("FAIL rnd_ar c%0d: got a=%0h id=%0h pf=%0h want a=%0h id=%0h pf=%0h", c, bus.arAddr, bus.arId, bus.arIsPrefetch, m_ar.addr, m_ar.id, m_ar.is_prefetch); end
            end
            n_cmp++; if (bus.pfReady !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_pfReady c%0d: got %0h want %0h", c, bus.pfReady, (mq.size() < DEPTH)); end
            n_cmp++; if (int'(bus.pfQueueCnt) != mq.size()) begin n_bad++; $display("FAIL rnd_qcnt c%0d: got %0d want %0d", c, bus.pfQueueCnt, mq.size()); end
            n_cmp++; if (int'(bus.outstandingReqCnt) != m_cnt) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, bus.outstandingReqCnt, m_cnt); end
            model_tick(g);
            clk_step();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_pf_stream();
        test_limit();
        test_starvation();
        test_backpressure();
        test_flush();
        test_count_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
